// File: rtl/uart_parity_engine.sv
// uart_parity_engine: frame-aware serial parity generator (even/odd/mark/space) with start/valid/ack handshake
//   clk, reset (sync, active-high); start latches mode and opens a frame; bit_valid/data_in feed data bits;
//   parity_ack releases DONE; parity_out/parity_valid/busy/overrun are registered outputs.
//   Optional receive-side check under UART_PARITY_CHECK_EN: rx_parity_in in, sticky parity_err out.
module uart_parity_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       bit_valid,
  input  logic       data_in,
  input  logic       parity_ack,
`ifdef UART_PARITY_CHECK_EN
  input  logic       rx_parity_in,
  output logic       parity_err,
`endif
  output logic       parity_out,
  output logic       parity_valid,
  output logic       busy,
  output logic       overrun
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic acc_q, acc_d, par_q, par_d, ovr_q, ovr_d, pv_q, busy_q, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  // mark/space force a constant; even/odd is the accumulated XOR optionally inverted
  function automatic logic par_f(input logic a, input logic [1:0] m);
    return m[1] ? ~m[0] : a ^ m[0];
  endfunction
`ifdef UART_PARITY_CHECK_EN
  logic rx_in;
  assign rx_in = rx_parity_in;
  assign parity_err = err_q;
`else
  logic rx_in;
  assign rx_in = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    par_d = par_q;
    ovr_d = ovr_q;
    err_d = err_q;
    if (start) begin
      state_d = ACCUM;
      acc_d = bit_valid & data_in;
      cnt_d = bit_valid ? CW'(1) : '0;
      mode_d = mode;
      ovr_d = 1'b0;
      err_d = 1'b0;
      if (bit_valid && cnt_d == LAST) begin
        state_d = DONE;
        par_d = par_f(acc_d, mode);
      end
    end else if (state_q == ACCUM) begin
      if (bit_valid) begin
        acc_d = acc_q ^ data_in;
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == LAST) begin
          state_d = DONE;
          par_d = par_f(acc_d, mode_q);
        end
      end
    end else begin
      ovr_d = ovr_q | bit_valid;
      if (state_q == DONE && parity_ack) begin
        state_d = IDLE;
        err_d = err_q | (rx_in != par_q);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= 1'b0;
      cnt_q <= '0;
      mode_q <= 2'b00;
      par_q <= 1'b0;
      ovr_q <= 1'b0;
      pv_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      par_q <= par_d;
      ovr_q <= ovr_d;
      pv_q <= state_d == DONE;
      busy_q <= state_d == ACCUM;
      err_q <= err_d;
    end
  end
  assign parity_out = par_q;
  assign parity_valid = pv_q;
  assign busy = busy_q;
  assign overrun = ovr_q;
endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised serial parity generator for the UART transmit path. It accumulates a frame's data bits one per qualified cycle and produces the parity bit in even, odd, mark or space mode. It uses a start/valid/ack handshake so the TX framer can fetch parity after the last data bit. It replaces the free-running single-bit XOR accumulator with frame-aware counting, mode selection and overrun detection.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 1..16; counter width is $clog2(DATA_WIDTH+1)
- clk  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-high reset
- start  in  1  begin new frame: clear accumulator/counter, latch mode
- mode  in  2  parity mode, sampled only on start: 00 even, 01 odd, 10 mark (1), 11 space (0)
- bit_valid  in  1  data_in is a data bit of the current frame this cycle
- data_in  in  1  serial data bit
- parity_ack  in  1  consumer has taken parity_out; releases DONE
- parity_out  out  1  registered parity bit, valid while parity_valid=1
- parity_valid  out  1  high in DONE state
- busy  out  1  high in ACCUM state
- overrun  out  1  sticky: bit_valid seen outside ACCUM

## Operation
- Synchronous active-high reset on clk; it is the only reset. Reset values: parity_out=0, parity_valid=0, busy=0, overrun=0, state=IDLE, acc=0, count=0, latched mode=00.
- States IDLE, ACCUM, DONE; encoding is free.
- start, in any state: acc←0, count←0, mode latched, overrun←0, state→ACCUM. Any frame in progress is abandoned.
- bit_valid while start is high: that bit is the first bit of the new frame, so acc←data_in and count←1.
- ACCUM with bit_valid: acc←acc^data_in, count←count+1.
- When the bit that makes count==DATA_WIDTH is accepted: state→DONE. parity_out←even: acc_final; odd: ~acc_final; mark: 1; space: 0. acc_final includes the current bit.
- DATA_WIDTH=1: start+bit_valid in the same cycle goes straight to DONE.
- DONE: parity_out and parity_valid hold until parity_ack. On parity_ack, state→IDLE and parity_valid←0. parity_out keeps its last value.
- start and parity_ack in the same cycle in DONE: start wins, and the next state is ACCUM.
- parity_ack outside DONE is ignored.
- bit_valid in IDLE or DONE without start: the bit is discarded and overrun←1. overrun is cleared only by start or reset.
- Mode changes after start have no effect on the current frame.

## Timing
- parity_valid rises 1 cycle after the clock edge that accepted the final bit_valid.
- Minimum frame time is DATA_WIDTH cycles from start (start+bit_valid together) to the last accept, plus 1 cycle to parity_valid.
- parity_valid falls 1 cycle after the parity_ack edge. Back-to-back frames are possible: start may be asserted in the same cycle as parity_ack.
- busy=1 exactly while in ACCUM. All outputs are registered and there are no combinational input-to-output paths.
- Reset mid-frame: the next cycle shows reset values, and the partial frame is lost.

## Configuration
- Macro UART_PARITY_CHECK_EN.
- Defined: adds two ports.
  - rx_parity_in  in  1
  - parity_err  out  1 (reset 0)
  - In DONE with parity_ack=1: parity_err←(rx_parity_in != parity_out). parity_err is sticky, cleared by start or reset.
  - This lets the same block check receive-side parity.
- Undefined: both ports are absent and the behaviour is exactly as above.

## Test plan
- DATA_WIDTH=8, even mode, start then bits 1,0,1,1,0,0,0,0 on consecutive cycles -> parity_out=1 and parity_valid=1 one cycle after the 8th bit; busy low in DONE.
- Same data in odd mode -> parity_out=0. Mark mode -> 1. Space mode -> 0. Bits 0xFF in even mode -> 0.
- Gaps: 8 bits spaced with idle cycles, and mode toggled mid-frame -> result matches the mode latched at start; parity_valid not raised early.
- bit_valid pulsed in IDLE, then again in DONE before ack -> overrun=1, parity_out unchanged; next start clears overrun.
- start asserted after 4 of 8 bits, then 8 new bits of 0x01 in even mode -> parity_out=1. start+parity_ack in the same cycle in DONE -> ACCUM, busy=1. Reset mid-frame -> all outputs 0 next cycle.
- With UART_PARITY_CHECK_EN, even mode, data 0x03 -> rx_parity_in=1 at ack gives parity_err=1; rx_parity_in=0 gives parity_err=0. parity_err clears on start.
